delay_meter: RTL and testbench
==============================

# delay_meter

Measures the latency, in clock cycles, between a rising edge on a launch signal and the next rising edge on a capture signal. It is the measuring end of the signal-delay path: `start_sig` taps the delayer input and `stop_sig` taps the delayed output. The measured count is returned through a valid/ready result port, with overflow and error flags. Typical uses are on-chip calibration and self-check of programmed delay values.

## Interface
- `CNT_W`, default 4: width of the measured delay. `MAX_CNT` = 2^CNT_W − 1.
- `clk`  in  1  clock; all logic on the rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `meas_en`  in  1  enables arming; deasserting it aborts any measurement in progress.
- `start_sig`  in  1  launch signal, level; its rising edge starts a measurement.
- `stop_sig`  in  1  capture signal, level; its rising edge ends the measurement.
- `delay_meas`  out  CNT_W  measured delay k, in cycles.
- `meas_ovf`  out  1  measurement saturated without a stop edge.
- `meas_err`  out  1  `start_sig` fell before a stop edge arrived.
- `meas_valid`  out  1  result fields are valid.
- `meas_ready`  in  1  consumer accepts the result.

## Operation
- **Edge detection:** registered previous values of `start_sig` and `stop_sig`, both reset to 0.
  - rise = (current level is 1) and (previous level is 0).
  - Edges are evaluated every cycle.
- **Definition of k:** the start rise is first sampled at edge t and the stop rise at edge t+k; the block reports `delay_meas` = k.
- **FSM states:** IDLE, COUNT, DONE. Reset state is IDLE.
- **IDLE:**
  - `meas_en` & start rise & stop rise in the same cycle → result 0, go to DONE.
  - `meas_en` & start rise only → count = 1, go to COUNT.
  - Otherwise stay in IDLE.
- **COUNT** (conditions in priority order):
  1. `meas_en` = 0 → IDLE. No result is produced and the flags are unchanged.
  2. Stop rise → result = count, ovf = 0, err = 0, go to DONE.
  3. `start_sig` = 0 → result = count, err = 1, go to DONE.
  4. count == MAX_CNT → result = MAX_CNT, ovf = 1, go to DONE.
  5. Otherwise count ← count + 1.
- **Counter:** never wraps. Measurable range is 0..MAX_CNT. A stop rise in the same cycle that count reaches MAX_CNT gives a clean result (ovf = 0).
- **DONE:**
  - `meas_valid` = 1.
  - `delay_meas`, `meas_ovf` and `meas_err` stay stable.
  - All input edges are ignored.
  - `meas_valid` & `meas_ready` → go to IDLE.
- **Output fields:** written only on entry to DONE; they hold their last value afterwards.
- **Handshake:**
  - The transfer occurs on a clock edge where `meas_valid` and `meas_ready` are both 1.
  - `meas_ready` may be held high continuously.
  - `meas_ready` while `meas_valid` = 0 has no effect.
- **Reset:** all outputs are 0, the counter is 0, the edge registers are 0 and the FSM is in IDLE. Asserting reset mid-measurement discards the measurement.

## Timing
- All outputs are registered.
- `meas_valid` rises on the cycle after the stop edge is sampled (or after the abort or saturation condition).
- Latency from stop rise to `meas_valid` = 1 cycle.
- `meas_valid` falls on the cycle after the accepting handshake.
- **Re-arming:** the earliest new start edge accepted is one sampled in IDLE, i.e. at least one cycle after acceptance.
  - A start rise sampled during DONE is lost; it is not queued.
- **Back-to-back measurements:** the minimum period is k + 2 cycles with `meas_ready` tied high.

## Structure
- `delay_meter_pkg`: `meas_state_t` enum (IDLE, COUNT, DONE) and a default `CNT_W` constant.
- Sub-module `rise_detect`: one-bit registered rising-edge detector with `clk` and `rstn`. It is instantiated twice, once for start and once for stop.
- FSM, counter and result registers live in `delay_meter`, in one `always_ff` block plus the next-state logic.

## Test plan
1. **Nominal delay:** `meas_en` = 1, `meas_ready` = 1, start rises at cycle 10, stop rises at cycle 14 → `delay_meas` = 4, ovf = 0, err = 0, `meas_valid` high for exactly 1 cycle at cycle 15.
2. **Zero delay:** start and stop rise in the same cycle → `delay_meas` = 0, `meas_valid` the next cycle.
3. **Saturation:** start held high with no stop for 20 cycles, CNT_W = 4 → `delay_meas` = 15, `meas_ovf` = 1. Separately, stop rising exactly 15 cycles after start → 15 with ovf = 0.
4. **Error abort:** start high for 3 cycles then low, stop never rises → `delay_meas` = 3, `meas_err` = 1.
5. **Backpressure:** `meas_ready` = 0 for 8 cycles after a k = 2 result.
   - `meas_valid` and the result stay stable.
   - A start edge during DONE is ignored.
   - Once `meas_ready` goes high, `meas_valid` drops the next cycle.
6. **Abort and reset:**
   - `meas_en` dropped mid-COUNT → back to IDLE with no `meas_valid`.
   - `rstn` asserted mid-COUNT → all outputs 0 immediately.
   - A subsequent measurement with k = 5 → 5.

Source files
------------

// File: rtl/delay_meter_pkg.sv
// Shared types and defaults for the launch-to-capture delay meter.
package delay_meter_pkg;

    localparam int unsigned CntWDefault = 4;

    typedef enum logic [1:0] {
        StIdle,
        StCount,
        StDone
    } meas_state_t;

endpackage

// File: rtl/delay_meter_rise_detect.sv
// One-bit registered rising-edge detector: flags a 0->1 transition of sig_i.
module rise_detect (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prev_q <= 1'b0;
        end else begin
            prev_q <= sig_i;
        end
    end

    assign rise_o = sig_i & ~prev_q;

endmodule

// File: rtl/delay_meter.sv
// Counts clock cycles from a start_sig rising edge to the next stop_sig rising edge and
// returns the count with overflow/error flags through a valid/ready result port.
module delay_meter
    import delay_meter_pkg::*;
#(
    parameter int unsigned CNT_W = CntWDefault
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             meas_en_i,
    input  logic             start_sig_i,
    input  logic             stop_sig_i,
    output logic [CNT_W-1:0] delay_meas_o,
    output logic             meas_ovf_o,
    output logic             meas_err_o,
    output logic             meas_valid_o,
    input  logic             meas_ready_i
);

    localparam logic [CNT_W-1:0] MaxCnt = {CNT_W{1'b1}};

    meas_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] meas_q, meas_d;
    logic             ovf_q, ovf_d;
    logic             err_q, err_d;
    logic             start_rise, stop_rise;

    rise_detect u_start_rise (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (start_sig_i),
        .rise_o (start_rise)
    );

    rise_detect u_stop_rise (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .sig_i  (stop_sig_i),
        .rise_o (stop_rise)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        meas_d  = meas_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (meas_en_i && start_rise) begin
                    if (stop_rise) begin
                        meas_d  = '0;
                        ovf_d   = 1'b0;
                        err_d   = 1'b0;
                        state_d = StDone;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = StCount;
                    end
                end
            end
            StCount: begin
                // Priority: abort, clean stop, start dropped, saturation.
                if (!meas_en_i) begin
                    state_d = StIdle;
                end else if (stop_rise) begin
                    meas_d  = cnt_q;
                    ovf_d   = 1'b0;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else if (!start_sig_i) begin
                    meas_d  = cnt_q;
                    ovf_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = StDone;
                end else if (cnt_q == MaxCnt) begin
                    meas_d  = MaxCnt;
                    ovf_d   = 1'b1;
                    err_d   = 1'b0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StDone: begin
                if (meas_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            meas_q  <= '0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            meas_q  <= meas_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    assign delay_meas_o = meas_q;
    assign meas_ovf_o   = ovf_q;
    assign meas_err_o   = err_q;
    assign meas_valid_o = (state_q == StDone);

endmodule

// File: tb/tb_delay_meter.sv
// Self-checking bench for delay_meter: scenario table, corner sequences, random vs model.
module tb_delay_meter;

    localparam int MaxC = 15;

    logic       clk = 1'b0;
    logic       rst_n, en, start, stop, ready;
    logic [3:0] dmeas;
    logic       ovf, err, valid;

    int n_vec  = 0;
    int n_miss = 0;

    delay_meter #(.CNT_W(4)) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .meas_en_i    (en),
        .start_sig_i  (start),
        .stop_sig_i   (stop),
        .delay_meas_o (dmeas),
        .meas_ovf_o   (ovf),
        .meas_err_o   (err),
        .meas_valid_o (valid),
        .meas_ready_i (ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        int stop_k;    // edge index of the stop rise, -1 for none
        int hold;      // start falls before this edge index, 0 keeps it high
        int exp_edge;  // edge after which meas_valid is first seen
        int exp_meas;
        bit exp_ovf;
        bit exp_err;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_meas(input int stop_k, input int hold, input bit rdy, output int seen);
        seen = -1;
        for (int e = 0; e <= 40; e++) begin
            start = (hold == 0) || (e < hold);
            stop  = (stop_k >= 0) && (e >= stop_k);
            ready = rdy;
            tick();
            if (valid) begin
                seen = e;
                break;
            end
        end
    endtask

    // Reference model: tracks elapsed edges since the accepted start edge.
    bit m_busy, m_valid, m_ovf, m_err, m_ps, m_pp;
    int m_t0, m_cyc, m_meas;

    task automatic m_reset();
        m_busy = 0; m_valid = 0; m_ovf = 0; m_err = 0; m_ps = 0; m_pp = 0;
        m_t0 = 0; m_cyc = 0; m_meas = 0;
    endtask

    task automatic m_finish(input int k, input bit o, input bit r);
        m_meas = k; m_ovf = o; m_err = r; m_valid = 1; m_busy = 0;
    endtask

    task automatic m_edge(input bit e, input bit s, input bit p, input bit r);
        bit srise, prise;
        int el;
        srise = s && !m_ps;
        prise = p && !m_pp;
        if (m_valid) begin
            if (r) m_valid = 0;
        end else if (m_busy) begin
            el = m_cyc - m_t0;
            if (!e) m_busy = 0;
            else if (prise) m_finish(el, 0, 0);
            else if (!s) m_finish(el, 0, 1);
            else if (el == MaxC) m_finish(MaxC, 1, 0);
        end else if (e && srise) begin
            if (prise) m_finish(0, 0, 0);
            else begin
                m_busy = 1;
                m_t0   = m_cyc;
            end
        end
        m_ps = s;
        m_pp = p;
        m_cyc++;
    endtask

    initial begin
        int seen;
        vecs[0] = '{4, 0, 4, 4, 0, 0};
        vecs[1] = '{0, 0, 0, 0, 0, 0};
        vecs[2] = '{1, 0, 1, 1, 0, 0};
        vecs[3] = '{-1, 0, 15, 15, 1, 0};
        vecs[4] = '{15, 0, 15, 15, 0, 0};
        vecs[5] = '{14, 0, 14, 14, 0, 0};
        vecs[6] = '{-1, 3, 3, 3, 0, 1};
        vecs[7] = '{-1, 1, 1, 1, 0, 1};
        vecs[8] = '{5, 5, 5, 5, 0, 0};

        rst_n = 0; en = 1; start = 0; stop = 0; ready = 1;
        #22;
        check("rst_valid", valid, 0);
        check("rst_meas", dmeas, 0);
        check("rst_ovf", ovf, 0);
        check("rst_err", err, 0);
        @(negedge clk) rst_n = 1;
        tick(); tick();

        foreach (vecs[i]) begin
            run_meas(vecs[i].stop_k, vecs[i].hold, 1'b1, seen);
            check($sformatf("v%0d_edge", i), seen, vecs[i].exp_edge);
            check($sformatf("v%0d_meas", i), dmeas, vecs[i].exp_meas);
            check($sformatf("v%0d_ovf", i), ovf, vecs[i].exp_ovf);
            check($sformatf("v%0d_err", i), err, vecs[i].exp_err);
            tick();
            check($sformatf("v%0d_vdrop", i), valid, 0);
            start = 0; stop = 0;
            tick(); tick();
        end

        // Backpressure with a start edge arriving while the result is held.
        run_meas(2, 0, 1'b0, seen);
        check("bp_edge", seen, 2);
        for (int i = 0; i < 8; i++) begin
            start = (i != 3);
            tick();
            check("bp_valid", valid, 1);
            check("bp_meas", dmeas, 2);
        end
        ready = 1;
        tick();
        check("bp_drop", valid, 0);
        stop = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("bp_lost_start", valid, 0);
            stop = ~stop;
        end
        start = 0; stop = 0;
        tick(); tick();

        // meas_en dropped mid-count: no result, previous fields untouched.
        start = 1; tick(); tick(); tick();
        en = 0; tick();
        check("abort_valid", valid, 0);
        en = 1; stop = 1;
        tick(); check("abort_valid2", valid, 0);
        tick(); check("abort_valid3", valid, 0);
        check("abort_meas_held", dmeas, 2);
        start = 0; stop = 0;
        tick(); tick();

        // Asynchronous reset mid-count, then a fresh k = 5 measurement.
        start = 1; tick(); tick(); tick();
        rst_n = 0;
        #1;
        check("mrst_valid", valid, 0);
        check("mrst_meas", dmeas, 0);
        check("mrst_ovf", ovf, 0);
        check("mrst_err", err, 0);
        start = 0;
        @(negedge clk) rst_n = 1;
        tick();
        run_meas(5, 0, 1'b1, seen);
        check("k5_edge", seen, 5);
        check("k5_meas", dmeas, 5);
        check("k5_ovf", ovf, 0);
        tick();
        check("k5_vdrop", valid, 0);

        // Random phase against the model, starting from a fresh reset.
        start = 0; stop = 0; en = 1; ready = 1;
        rst_n = 0;
        #3;
        @(negedge clk) rst_n = 1;
        m_reset();
        tick();
        m_edge(en, start, stop, ready);
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(5, 0) == 0) start = ~start;
            if ($urandom_range(2, 0) == 0) stop = ~stop;
            en    = ($urandom_range(29, 0) != 0);
            ready = ($urandom_range(2, 0) != 0);
            m_edge(en, start, stop, ready);
            tick();
            check("rnd_valid", valid, m_valid);
            check("rnd_meas", dmeas, m_meas);
            check("rnd_ovf", ovf, m_ovf);
            check("rnd_err", err, m_err);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
